seq_array_multiplier: RTL and testbench



---
 rtl/seq_array_multiplier.sv | 117 +++++++++++
 tb/tb_seq_array_multiplier.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_array_multiplier.sv
// seq_array_multiplier: sequential shift-add multiplier with optional signed
// (two's complement) mode. It retires one partial product per clock.
//
// Handshake: a request is accepted at a rising edge where start=1 and the
// block is ready (IDLE or DONE). After acceptance, busy is high through the
// BUSY and FIXUP cycles. Then done pulses for exactly one cycle, and Product
// is valid in that cycle. Product holds its value until the next result.
// A, B and signed_mode are sampled only at the accepting edge.
module seq_array_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg;

    logic               accept;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_in;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_shift;
    logic [2*WIDTH-1:0] prod_fix;

    // Accept a new request when ready and form the operand magnitudes. The
    // most negative operand negates to itself, which is its correct
    // unsigned magnitude.
    always_comb begin
        accept = start && ((state == IDLE) || (state == DONE));
        a_mag  = (signed_mode && A[WIDTH-1]) ? -A : A;
        b_mag  = (signed_mode && B[WIDTH-1]) ? -B : B;
        neg_in = signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
    end

    // One shift-add step: add the multiplicand into the upper half with the
    // carry kept, then shift the whole accumulator right by one bit.
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_shift = {sum, acc[WIDTH-1:1]};
        prod_fix  = neg ? -acc : acc;
    end

    // Next-state logic. A start in BUSY or FIXUP is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (count == CW'(1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register. Reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: capture on accept, iterate in BUSY, and write the
    // sign-corrected result in FIXUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            Product <= '0;
        end else if (accept) begin
            count  <= CW'(WIDTH);
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
            neg    <= neg_in;
        end else if (state == BUSY) begin
            acc    <= acc_shift;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end else if (state == FIXUP) begin
            Product <= prod_fix;
        end
    end

    assign busy      = (state == BUSY) || (state == FIXUP);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Bench for seq_array_multiplier. It instantiates the multiplier at widths
// 4, 6 and 8. Results are compared against an integer reference product.
module tb_seq_array_multiplier;

    logic clk;
    logic rst;

    logic       start4, s4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    logic [1:0] st4;

    logic        start6, s6, busy6, done6;
    logic [5:0]  a6, b6;
    logic [11:0] p6;
    logic [1:0]  st6;

    logic        start8, s8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic [1:0]  st8;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    seq_array_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(s4), .A(a4), .B(b4),
        .Product(p4), .busy(busy4), .done(done4), .state_dbg(st4));

    seq_array_multiplier #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .signed_mode(s6), .A(a6), .B(b6),
        .Product(p6), .busy(busy6), .done(done6), .state_dbg(st6));

    seq_array_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(s8), .A(a8), .B(b8),
        .Product(p8), .busy(busy8), .done(done8), .state_dbg(st8));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: plain integer multiply of the (optionally signed) operands
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
        longint m, av, bv, pr;
        m  = (longint'(1) << w) - 1;
        av = longint'(a) & m;
        bv = longint'(b) & m;
        if (s && av[w-1]) av = av - (longint'(1) << w);
        if (s && bv[w-1]) bv = bv - (longint'(1) << w);
        pr = av * bv;
        pr = pr & ((longint'(1) << (2 * w)) - 1);
        return 64'(pr);
    endfunction

    // driver tasks
    task automatic drive(input int w, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
        case (w)
            4: begin start4 = st; a4 = a[3:0]; b4 = b[3:0]; s4 = s; end
            6: begin start6 = st; a6 = a[5:0]; b6 = b[5:0]; s6 = s; end
            8: begin start8 = st; a8 = a[7:0]; b8 = b[7:0]; s8 = s; end
            default: ;
        endcase
    endtask

    function automatic logic get_done(input int w);
        case (w)
            4: return done4;
            6: return done6;
            default: return done8;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            4: return busy4;
            6: return busy6;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [63:0] get_prod(input int w);
        case (w)
            4: return 64'(p4);
            6: return 64'(p6);
            default: return 64'(p8);
        endcase
    endfunction

    // Issue one request, which is accepted at the next edge. Then count the
    // edges until done is seen. lat = -1 means done never arrived.
    task automatic run_mul(input int w, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input bit scramble,
                           output logic [63:0] p, output int lat,
                           output logic busy1, output logic overlap);
        drive(w, 1'b1, a, b, s);
        @(posedge clk); #1;
        drive(w, 1'b0, a, b, s);
        busy1   = get_busy(w);
        overlap = 1'b0;
        lat     = -1;
        p       = '0;
        for (int i = 1; i <= 40; i++) begin
            if (scramble) drive(w, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
            if (get_busy(w) && get_done(w)) overlap = 1'b1;
            if (get_done(w)) begin
                lat = i;
                p   = get_prod(w);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4, 1'b0, 0, 0, 1'b0);
        drive(6, 1'b0, 0, 0, 1'b0);
        drive(8, 1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int w;
            w = (k == 0) ? 4 : (k == 1) ? 6 : 8;
            total++;
            if (get_prod(w) !== 64'd0) begin
                bad++; $display("FAIL reset_product w=%0d got=%0h exp=0", w, get_prod(w));
            end
            total++;
            if (get_busy(w) !== 1'b0 || get_done(w) !== 1'b0) begin
                bad++; $display("FAIL reset_flags w=%0d busy=%b done=%b exp=0/0", w, get_busy(w), get_done(w));
            end
        end
    endtask

    task automatic test_unsigned();
        int ua[4] = '{3, 13, 6, 15};
        int ub[4] = '{5, 2, 10, 15};
        int ue[4] = '{15, 26, 60, 225};
        logic [63:0] p; int lat; logic b1, ov;
        for (int i = 0; i < 4; i++) begin
            run_mul(4, ua[i], ub[i], 1'b0, 1'b0, p, lat, b1, ov);
            total++;
            if (p !== 64'(ue[i])) begin
                bad++; $display("FAIL unsigned_%0dx%0d got=%0d exp=%0d", ua[i], ub[i], p, ue[i]);
            end
            total++;
            if (lat !== 5) begin
                bad++; $display("FAIL unsigned_latency got=%0d exp=5", lat);
            end
            total++;
            if (b1 !== 1'b1 || ov !== 1'b0) begin
                bad++; $display("FAIL unsigned_busy busy_after_accept=%b overlap=%b exp=1/0", b1, ov);
            end
        end
    endtask

    task automatic test_signed();
        int sa[4] = '{4'hD, 4'h8, 4'h8, 4'h0};
        int sb[4] = '{4'h5, 4'h8, 4'h7, 4'hB};
        int se[4] = '{8'hF1, 8'h40, 8'hC8, 8'h00};
        logic [63:0] p; int lat; logic b1, ov;
        for (int i = 0; i < 4; i++) begin
            run_mul(4, sa[i], sb[i], 1'b1, 1'b0, p, lat, b1, ov);
            total++;
            if (p !== 64'(se[i]) || lat !== 5) begin
                bad++; $display("FAIL signed_%0h_%0h got=%0h lat=%0d exp=%0h lat=5", sa[i], sb[i], p, lat, se[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] p1, p2; int lat1, gap;
        lat1 = -1; gap = -1; p1 = '0; p2 = '0;
        drive(4, 1'b1, 3, 5, 1'b0);
        @(posedge clk); #1;
        drive(4, 1'b1, 2, 7, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done4) begin lat1 = i; p1 = 64'(p4); break; end
        end
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done4) begin gap = i; p2 = 64'(p4); break; end
        end
        drive(4, 1'b0, 0, 0, 1'b0);
        total++;
        if (p1 !== 64'd15 || lat1 !== 5) begin
            bad++; $display("FAIL b2b_first got=%0d lat=%0d exp=15 lat=5", p1, lat1);
        end
        total++;
        if (p2 !== 64'd14 || gap !== 6) begin
            bad++; $display("FAIL b2b_second got=%0d gap=%0d exp=14 gap=6", p2, gap);
        end
        @(posedge clk); #1;
        total++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            bad++; $display("FAIL b2b_idle done=%b busy=%b exp=0/0", done4, busy4);
        end
    endtask

    task automatic test_ignored_start();
        logic [63:0] p; int lat, extra;
        lat = -1; p = '0; extra = 0;
        drive(4, 1'b1, 6, 10, 1'b0);
        @(posedge clk); #1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 2) drive(4, 1'b1, 15, 15, 1'b1);
            else        drive(4, 1'b0, 6, 10, 1'b0);
            @(posedge clk); #1;
            if (done4) begin lat = i; p = 64'(p4); break; end
        end
        drive(4, 1'b0, 0, 0, 1'b0);
        total++;
        if (p !== 64'd60 || lat !== 5) begin
            bad++; $display("FAIL ignored_start got=%0d lat=%0d exp=60 lat=5", p, lat);
        end
        repeat (8) begin
            @(posedge clk); #1;
            if (done4) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++; $display("FAIL ignored_start_extra_done got=%0d exp=0", extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] p; int lat, dcount; logic b1, ov;
        dcount = 0;
        drive(4, 1'b1, 15, 15, 1'b0);
        @(posedge clk); #1;
        drive(4, 1'b0, 15, 15, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (p4 !== 8'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            bad++; $display("FAIL reset_mid_outputs prod=%0h busy=%b done=%b exp=0/0/0", p4, busy4, done4);
        end
        repeat (10) begin
            @(posedge clk); #1;
            if (done4) dcount++;
        end
        total++;
        if (dcount !== 0) begin
            bad++; $display("FAIL reset_mid_done got=%0d exp=0", dcount);
        end
        run_mul(4, 3, 5, 1'b0, 1'b0, p, lat, b1, ov);
        total++;
        if (p !== 64'd15 || lat !== 5) begin
            bad++; $display("FAIL reset_mid_recover got=%0d lat=%0d exp=15 lat=5", p, lat);
        end
        // reset and start in the same cycle: reset wins
        drive(4, 1'b1, 9, 9, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(4, 1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'd0) begin
            bad++; $display("FAIL rst_start busy=%b done=%b prod=%0h exp=0/0/0", busy4, done4, p4);
        end
    endtask

    task automatic test_wide();
        int wa[3] = '{255, 8'h80, 127};
        int wb[3] = '{255, 8'h80, 8'hFF};
        logic ws[3] = '{1'b0, 1'b1, 1'b1};
        int we[3] = '{16'hFE01, 16'h4000, 16'hFF81};
        logic [63:0] p; int lat; logic b1, ov;
        for (int i = 0; i < 3; i++) begin
            run_mul(8, wa[i], wb[i], ws[i], 1'b0, p, lat, b1, ov);
            total++;
            if (p !== 64'(we[i]) || lat !== 9) begin
                bad++; $display("FAIL wide_%0d got=%0h lat=%0d exp=%0h lat=9", i, p, lat, we[i]);
            end
            total++;
            if (b1 !== 1'b1 || ov !== 1'b0) begin
                bad++; $display("FAIL wide_busy busy_after_accept=%b overlap=%b exp=1/0", b1, ov);
            end
        end
    endtask

    task automatic test_stability();
        logic [63:0] p, e; int lat; logic b1, ov;
        run_mul(4, 13, 2, 1'b0, 1'b1, p, lat, b1, ov);
        total++;
        if (p !== 64'd26) begin
            bad++; $display("FAIL stability_13x2 got=%0d exp=26", p);
        end
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b;
            logic s;
            a = $urandom_range(0, 63);
            b = $urandom_range(0, 63);
            s = 1'(i % 2);
            exp_q.push_back(ref_mul(6, a, b, s));
            run_mul(6, a, b, s, 1'b1, p, lat, b1, ov);
            e = exp_q.pop_front();
            total++;
            if (p !== e || lat !== 7 || ov !== 1'b0) begin
                bad++;
                $display("FAIL random_w6 a=%0h b=%0h s=%b got=%0h lat=%0d exp=%0h lat=7", a, b, s, p, lat, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        test_wide();
        test_stability();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
